// File: rtl/fdtd_calc_hy_stream_if.sv
// Stream bundle for the Hy update engine: Ez/Hy_old beats in, updated Hy out.
// slave is the engine side; master is the producer/consumer side.
interface fdtd_calc_hy_stream_if #(
    parameter int unsigned W = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] Ez_n_i;
    logic [W-1:0] Hy_old_i;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] Hy_n_o;
    logic         out_last;

    modport slave (
        input  in_valid, Ez_n_i, Hy_old_i, out_ready,
        output in_ready, out_valid, Hy_n_o, out_last
    );

    modport master (
        output in_valid, Ez_n_i, Hy_old_i, out_ready,
        input  in_ready, out_valid, Hy_n_o, out_last
    );
endinterface

// File: rtl/fdtd_calc_hy_stream.sv
// Streaming 1-D FDTD Hy update: Hy_n[i] = chyh*Hy_old[i] + chyez*(Ez_n[i+1] - Ez_n[i]),
// with Ez past the last cell taken as 0. Three register stages behind a pairing stage.
module fdtd_calc_hy_stream #(
    parameter int unsigned FDTD_DATA_WIDTH = 32,
    parameter int unsigned CUT_LT          = 51,
    parameter int unsigned CUT_RT          = 21,
    parameter int unsigned CNT_WIDTH       = 16
) (
    input  logic                       CLK,
    input  logic                       RST_N,
    input  logic                       start,
    input  logic [CNT_WIDTH-1:0]       ncells,
    input  logic [FDTD_DATA_WIDTH-1:0] chyh,
    input  logic [FDTD_DATA_WIDTH-1:0] chyez,
    fdtd_calc_hy_stream_if.slave       bus,
    output logic                       busy,
    output logic                       done
);

    localparam int unsigned W  = FDTD_DATA_WIDTH;
    localparam int unsigned PW = 2 * W;

    typedef enum logic [1:0] {StIdle, StRun, StFlush, StDrain} state_e;

    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] ncells_q, ncells_d;
    logic [CNT_WIDTH-1:0] in_cnt_q, in_cnt_d;
    logic [CNT_WIDTH-1:0] out_cnt_q, out_cnt_d;
    logic [CNT_WIDTH-1:0] last_cnt;
    logic [W-1:0]         chyh_q, chyh_d, chyez_q, chyez_d;
    logic [W-1:0]         ez_prev_q, ez_prev_d, hy_prev_q, hy_prev_d;
    logic                 done_q, done_d;

    logic                 s1_valid_q, s2_valid_q, out_valid_q;
    logic [W-1:0]         s1_diff_q, s1_hy_q, hy_n_q;
    logic [PW-1:0]        p0_q, p1_q, p0_d, p1_d;
    logic [W-1:0]         sum_d;

    logic                 pipe_en, in_ready_w, accept, out_hs, out_last_w;
    logic                 issue;
    logic [W-1:0]         issue_diff;
    logic [PW-1:0]        diff_ext, hy_ext, chyez_ext, chyh_ext;
    logic                 unused_prod;

    // Whole pipeline moves as one; a stalled output freezes every stage.
    assign pipe_en    = !out_valid_q || bus.out_ready;
    assign in_ready_w = (state_q == StRun) && pipe_en;
    assign accept     = bus.in_valid && in_ready_w;
    assign out_hs     = out_valid_q && bus.out_ready;
    assign last_cnt   = ncells_q - CNT_WIDTH'(1);
    assign out_last_w = out_valid_q && (out_cnt_q == last_cnt);

    always_comb begin
        state_d    = state_q;
        ncells_d   = ncells_q;
        chyh_d     = chyh_q;
        chyez_d    = chyez_q;
        in_cnt_d   = in_cnt_q;
        out_cnt_d  = out_cnt_q;
        ez_prev_d  = ez_prev_q;
        hy_prev_d  = hy_prev_q;
        done_d     = 1'b0;
        issue      = 1'b0;
        issue_diff = '0;
        if (out_hs) begin
            out_cnt_d = out_cnt_q + CNT_WIDTH'(1);
        end
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    ncells_d  = ncells;
                    chyh_d    = chyh;
                    chyez_d   = chyez;
                    in_cnt_d  = '0;
                    out_cnt_d = '0;
                    if (ncells == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                if (accept) begin
                    in_cnt_d  = in_cnt_q + CNT_WIDTH'(1);
                    ez_prev_d = bus.Ez_n_i;
                    hy_prev_d = bus.Hy_old_i;
                    // The first beat of a line only primes the held pair.
                    if (in_cnt_q != '0) begin
                        issue      = 1'b1;
                        issue_diff = bus.Ez_n_i - ez_prev_q;
                    end
                    if (in_cnt_q == last_cnt) begin
                        state_d = StFlush;
                    end
                end
            end
            StFlush: begin
                if (pipe_en) begin
                    issue      = 1'b1;
                    issue_diff = {W{1'b0}} - ez_prev_q;
                    state_d    = StDrain;
                end
            end
            StDrain: begin
                if (out_hs && out_last_w) begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= StIdle;
            ncells_q  <= '0;
            chyh_q    <= '0;
            chyez_q   <= '0;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            ez_prev_q <= '0;
            hy_prev_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ncells_q  <= ncells_d;
            chyh_q    <= chyh_d;
            chyez_q   <= chyez_d;
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
            ez_prev_q <= ez_prev_d;
            hy_prev_q <= hy_prev_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        diff_ext  = {{W{s1_diff_q[W-1]}}, s1_diff_q};
        hy_ext    = {{W{s1_hy_q[W-1]}}, s1_hy_q};
        chyez_ext = {{W{chyez_q[W-1]}}, chyez_q};
        chyh_ext  = {{W{chyh_q[W-1]}}, chyh_q};
        p0_d      = diff_ext * chyez_ext;
        p1_d      = hy_ext * chyh_ext;
        // Keep the sign bit plus the fixed-point window of each product.
        sum_d     = {p0_q[PW-1], p0_q[CUT_LT:CUT_RT]} + {p1_q[PW-1], p1_q[CUT_LT:CUT_RT]};
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            s1_valid_q  <= 1'b0;
            s1_diff_q   <= '0;
            s1_hy_q     <= '0;
            s2_valid_q  <= 1'b0;
            p0_q        <= '0;
            p1_q        <= '0;
            out_valid_q <= 1'b0;
            hy_n_q      <= '0;
        end else if (pipe_en) begin
            s1_valid_q  <= issue;
            s1_diff_q   <= issue_diff;
            s1_hy_q     <= hy_prev_q;
            s2_valid_q  <= s1_valid_q;
            p0_q        <= p0_d;
            p1_q        <= p1_d;
            out_valid_q <= s2_valid_q;
            hy_n_q      <= sum_d;
        end
    end

    assign unused_prod = ^{p0_q[PW-2:CUT_LT+1], p0_q[CUT_RT-1:0],
                           p1_q[PW-2:CUT_LT+1], p1_q[CUT_RT-1:0]};

    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = out_valid_q;
    assign bus.Hy_n_o    = hy_n_q;
    assign bus.out_last  = out_last_w;
    assign busy          = (state_q != StIdle);
    assign done          = done_q;

endmodule

// File: doc/fdtd_calc_hy_stream.md
Name: fdtd_calc_Hy_stream

Overview:
- Streaming 1-D FDTD magnetic-field update engine; the H-side counterpart of the Ez update.
- Consumes one beat per cell carrying the updated Ez and the old Hy, and emits the updated Hy for each cell:
  Hy_n[i] = chyh*Hy_old[i] + chyez*(Ez_n[i+1] - Ez_n[i]).
- Ez beyond the last cell is treated as 0 (PEC end wall).
- Sits between the Ez engine output stream and the Hy field memory writer; has full valid/ready backpressure.

Parameters:
- FDTD_DATA_WIDTH, 32, field/coefficient word width (two's complement).
- CUT_LT, 51, MSB of the product slice kept.
- CUT_RT, 21, LSB of the product slice kept; constraint CUT_LT-CUT_RT+2 == FDTD_DATA_WIDTH.
- CNT_WIDTH, 16, cell counter width.

Ports:
- CLK  in  1  clock.
- RST_N  in  1  reset; asynchronous, active-low.
- start  in  1  one-cycle pulse; begins a line; ignored while busy.
- ncells  in  CNT_WIDTH  number of cells in line; sampled on start.
- chyh  in  FDTD_DATA_WIDTH  Hy self coefficient; sampled on start.
- chyez  in  FDTD_DATA_WIDTH  curl coefficient; sampled on start.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid && in_ready.
- Ez_n_i  in  FDTD_DATA_WIDTH  updated Ez of current cell.
- Hy_old_i  in  FDTD_DATA_WIDTH  old Hy of current cell.
- out_valid  out  1  Hy_n_o valid.
- out_ready  in  1  downstream accepts.
- Hy_n_o  out  FDTD_DATA_WIDTH  updated Hy.
- out_last  out  1  marks cell ncells-1.
- busy  out  1  line in progress (RUN, FLUSH or DRAIN).
- done  out  1  one-cycle pulse after last output handshake.

Behaviour:
- Reset: all outputs 0 (in_ready, out_valid, Hy_n_o, out_last, busy, done); FSM to IDLE; pipeline valids cleared; coefficient and count registers cleared.
- Reset mid-line: the line is abandoned and no output completes.
- FSM states: IDLE, RUN, FLUSH, DRAIN.
  - IDLE: start with ncells==0 -> done pulse next cycle, stay IDLE, no output. Start with ncells>0 -> RUN.
  - RUN: accepts beats until ncells beats are accepted, then -> FLUSH.
  - FLUSH: injects the boundary cell with Ez_next=0 when the pipeline advances, then -> DRAIN.
  - DRAIN: waits for the out_last handshake, then pulses done -> IDLE.
- Stall control:
  - pipe_en = !out_valid || out_ready. All stages advance only when pipe_en.
  - in_ready = (state==RUN) && pipe_en.
- Pairing stage:
  - The first accepted beat is only held as (Ez_prev, Hy_prev); it issues nothing.
  - Every later beat issues cell i with diff = Ez_n_i - Ez_prev and Hy_prev, then replaces the held pair.
  - FLUSH issues diff = 0 - Ez_prev with Hy_prev.
- Pipeline:
  - S1 registers diff and Hy.
  - S2 registers the full 2W-bit products P0 = diff*chyez and P1 = Hy*chyh.
  - S3 registers Hy_n_o = cut(P0) + cut(P1), where cut(P) = {P[2W-1], P[CUT_LT:CUT_RT]}. This equals an arithmetic shift right by CUT_RT (floor) when in range.
  - Latency: Hy_n_o for cell i is valid 3 cycles after the edge accepting beat i+1 (or after the FLUSH issue), absent stalls.
- Arithmetic: diff and final sum wrap modulo 2^W; no saturation.
- out_last is asserted with cell ncells-1 only. An output counter tracks emitted cells.
- Handshake rules:
  - out_valid and Hy_n_o hold stable while out_valid && !out_ready.
  - A stall freezes all stage contents; no data is lost or duplicated.
  - In-flight data advances through stages during FLUSH and DRAIN.
- Coefficients are used from the registered copies only; changing chyh/chyez mid-line has no effect.
- start during busy is ignored; counters and state are unaffected.

Test Plan:
- Basic: chyh=2097152 (1.0), chyez=1048576 (0.5), ncells=3, Ez_n = 100, 300, 200, Hy_old = 10, 20, 30; out_ready=1, back-to-back beats -> Hy_n_o = 110, -30, -70. out_last on third output; done 1 cycle after third handshake.
- Single cell: ncells=1, Ez_n=200, Hy_old=30, same coefficients -> one output -70 with out_last=1, then done.
- Zero cells: start with ncells=0 -> done pulses next cycle; out_valid never asserts; busy stays 0.
- Backpressure: basic case with out_ready toggled 1,0,0,1,0,1... -> identical values and order; Hy_n_o stable while stalled; in_ready low whenever out_valid && !out_ready.
- Rounding and wrap:
  - chyez=1048576, Ez_n = 0, 1, Hy_old = 0, 0, chyh=0 -> first output floor(0.5)=0, second (0-1)*0.5 -> -1.
  - Ez_n = 0x7FFFFFFF then 0x80000000 -> diff wraps to 1.
- Reset and ignore: assert RST_N low after 2 beats of a 5-cell line -> all outputs 0, IDLE. A new line then runs correctly; start pulsed while busy is ignored.
